// File: rtl/spi_fl_pkg.sv
// Shared opcodes, FSM state encoding and length constants for the SPI flash-style responder.
// The 4-byte address opcodes exist only when SPI_SLAVE_4BYTE_ADDR_EN is defined.
package spi_fl_pkg;

    localparam logic [7:0] OP_READ    = 8'h03;
    localparam logic [7:0] OP_PROGRAM = 8'h02;
    localparam logic [7:0] OP_RDSR    = 8'h05;
    localparam logic [7:0] OP_RDID    = 8'h9F;
    localparam logic [7:0] OP_WREN    = 8'h06;
    localparam logic [7:0] OP_WRDI    = 8'h04;
`ifdef SPI_SLAVE_4BYTE_ADDR_EN
    localparam logic [7:0] OP_EN4B    = 8'hB7;
    localparam logic [7:0] OP_EX4B    = 8'hE9;
`endif

    localparam int RD_LEN_READ = 32;
    localparam int RD_LEN_RDSR = 8;
    localparam int RD_LEN_RDID = 24;
    localparam int ADDR3_W     = 24;
    localparam int ADDR4_W     = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_TURN,
        ST_RDATA,
        ST_IGNORE
    } fl_state_t;

    // Number of miso bits returned by a read-type opcode; zero for everything else.
    function automatic logic [5:0] rd_len_of(input logic [7:0] op);
        case (op)
            OP_READ: return 6'(RD_LEN_READ);
            OP_RDSR: return 6'(RD_LEN_RDSR);
            OP_RDID: return 6'(RD_LEN_RDID);
            default: return 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/spi_fl_sync.sv
// Synchroniser for the asynchronous SPI pins plus registered edge detection of sclk and ss.
// Edge pulses and mosi_s leave SYNC_STAGES+1 clk after the pin change, mutually aligned.
module spi_fl_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic ss,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic ss_fall,
    output logic ss_rise,
    output logic mosi_s
);

    logic [SYNC_STAGES-1:0] sclk_sh;
    logic [SYNC_STAGES-1:0] ss_sh;
    logic [SYNC_STAGES-1:0] mosi_sh;
    logic                   sclk_d;
    logic                   ss_d;

    // ss resets to its idle (high) level so a held-low select is seen as a fresh fall after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sh   <= '0;
            ss_sh     <= '1;
            mosi_sh   <= '0;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b1;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            ss_fall   <= 1'b0;
            ss_rise   <= 1'b0;
            mosi_s    <= 1'b0;
        end else begin
            sclk_sh   <= {sclk_sh[SYNC_STAGES-2:0], sclk};
            ss_sh     <= {ss_sh[SYNC_STAGES-2:0], ss};
            mosi_sh   <= {mosi_sh[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_sh[SYNC_STAGES-1];
            ss_d      <= ss_sh[SYNC_STAGES-1];
            sclk_rise <= sclk_sh[SYNC_STAGES-1] & ~sclk_d;
            sclk_fall <= ~sclk_sh[SYNC_STAGES-1] & sclk_d;
            ss_fall   <= ~ss_sh[SYNC_STAGES-1] & ss_d;
            ss_rise   <= ss_sh[SYNC_STAGES-1] & ~ss_d;
            mosi_s    <= mosi_sh[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/spi_slave_fl.sv
// SPI mode-0 flash-style responder: decodes command/address/write data, issues one back-end request
// per transaction and serialises read data LSB first. 4-byte addressing is built with SPI_SLAVE_4BYTE_ADDR_EN.
module spi_slave_fl
    import spi_fl_pkg::*;
#(
    parameter int TURN_CYC    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        ss,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    output logic        req_valid,
    output logic        req_write,
    output logic [7:0]  req_cmd,
    output logic [31:0] req_addr,
    output logic [31:0] req_wdata,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    output logic        busy,
    output logic        err_unknown,
    output logic        rsp_late
);

    logic        sclk_rise, sclk_fall, ss_fall, ss_rise, mosi_s;
    fl_state_t   state, state_n, dec_state;
    logic [30:0] sr;
    logic [31:0] shift_word, addr_val, rsp_buf;
    logic [30:0] tx_sr;
    logic [5:0]  bit_cnt, cnt_inc, addr_last, rd_len;
    logic        rsp_wait, rsp_have, cmd_done;
    logic        dec_req, dec_rd, dec_err;

    spi_fl_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .ss        (ss),
        .mosi      (mosi),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .ss_fall   (ss_fall),
        .ss_rise   (ss_rise),
        .mosi_s    (mosi_s)
    );

`ifdef SPI_SLAVE_4BYTE_ADDR_EN
    logic addr4, dec_set4, dec_clr4;
    assign addr_last = addr4 ? 6'(ADDR4_W - 1) : 6'(ADDR3_W - 1);
`else
    assign addr_last = 6'(ADDR3_W - 1);
`endif

    assign shift_word = {sr, mosi_s};
    assign cnt_inc    = (bit_cnt == 6'h3F) ? bit_cnt : bit_cnt + 6'd1;
    assign addr_val   = (addr_last == 6'(ADDR4_W - 1)) ? shift_word : {8'h00, shift_word[23:0]};
    assign cmd_done   = (state == ST_CMD) && sclk_rise && (bit_cnt == 6'd7) && !ss_rise;
    assign busy       = (state != ST_IDLE);

    always_comb begin
        dec_state = ST_IGNORE;
        dec_req   = 1'b0;
        dec_rd    = 1'b0;
        dec_err   = 1'b0;
`ifdef SPI_SLAVE_4BYTE_ADDR_EN
        dec_set4  = 1'b0;
        dec_clr4  = 1'b0;
`endif
        case (shift_word[7:0])
            OP_READ, OP_PROGRAM: dec_state = ST_ADDR;
            OP_RDSR, OP_RDID: begin
                dec_state = ST_TURN;
                dec_req   = 1'b1;
                dec_rd    = 1'b1;
            end
            OP_WREN, OP_WRDI: dec_req = 1'b1;
`ifdef SPI_SLAVE_4BYTE_ADDR_EN
            OP_EN4B: dec_set4 = 1'b1;
            OP_EX4B: dec_clr4 = 1'b1;
`endif
            default: dec_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (ss_rise) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (ss_fall) state_n = ST_CMD;
                ST_CMD:   if (cmd_done) state_n = dec_state;
                ST_ADDR:  if (sclk_rise && bit_cnt == addr_last)
                              state_n = (req_cmd == OP_READ) ? ST_TURN : ST_WDATA;
                ST_WDATA: if (sclk_rise && bit_cnt == 6'd31) state_n = ST_IGNORE;
                ST_TURN:  if (sclk_fall && bit_cnt == 6'(TURN_CYC)) state_n = ST_RDATA;
                default:  state_n = state;
            endcase
        end
    end

    // In TURN the bit counter counts sclk falls; the fall numbered TURN_CYC is the read deadline.
    always_ff @(posedge clk) begin
        req_valid   <= 1'b0;
        err_unknown <= 1'b0;
        rsp_late    <= 1'b0;
        if (rst) begin
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            req_write <= 1'b0;
            req_cmd   <= 8'h00;
            req_addr  <= 32'h0;
            req_wdata <= 32'h0;
            sr        <= '0;
            tx_sr     <= '0;
            rsp_buf   <= 32'h0;
            bit_cnt   <= 6'd0;
            rd_len    <= 6'd0;
            rsp_wait  <= 1'b0;
            rsp_have  <= 1'b0;
        end else begin
            miso_oe <= (state_n == ST_TURN) || (state_n == ST_RDATA);
            if (rsp_valid && rsp_wait && !rsp_have) begin
                rsp_buf  <= rsp_data;
                rsp_have <= 1'b1;
            end
            if (ss_rise) begin
                miso     <= 1'b0;
                bit_cnt  <= 6'd0;
                rsp_wait <= 1'b0;
                rsp_have <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: if (ss_fall) begin
                        bit_cnt  <= sclk_rise ? 6'd1 : 6'd0;
                        if (sclk_rise) sr <= shift_word[30:0];
                        rsp_wait <= 1'b0;
                        rsp_have <= 1'b0;
                    end
                    ST_CMD: if (sclk_rise) begin
                        sr      <= shift_word[30:0];
                        bit_cnt <= cnt_inc;
                        if (bit_cnt == 6'd7) begin
                            bit_cnt     <= 6'd0;
                            req_cmd     <= shift_word[7:0];
                            rd_len      <= rd_len_of(shift_word[7:0]);
                            err_unknown <= dec_err;
                            if (dec_req) begin
                                req_valid <= 1'b1;
                                req_write <= 1'b0;
                                req_addr  <= 32'h0;
                            end
                            if (dec_rd) rsp_wait <= 1'b1;
                        end
                    end
                    ST_ADDR: if (sclk_rise) begin
                        sr      <= shift_word[30:0];
                        bit_cnt <= cnt_inc;
                        if (bit_cnt == addr_last) begin
                            bit_cnt  <= 6'd0;
                            req_addr <= addr_val;
                            if (req_cmd == OP_READ) begin
                                req_valid <= 1'b1;
                                req_write <= 1'b0;
                                rsp_wait  <= 1'b1;
                            end
                        end
                    end
                    ST_WDATA: if (sclk_rise) begin
                        sr      <= shift_word[30:0];
                        bit_cnt <= cnt_inc;
                        if (bit_cnt == 6'd31) begin
                            req_wdata <= shift_word;
                            req_valid <= 1'b1;
                            req_write <= 1'b1;
                        end
                    end
                    ST_TURN: if (sclk_fall) begin
                        if (bit_cnt == 6'(TURN_CYC)) begin
                            miso     <= rsp_have & rsp_buf[0];
                            tx_sr    <= rsp_have ? rsp_buf[31:1] : '0;
                            rsp_late <= !rsp_have;
                            rsp_wait <= 1'b0;
                            bit_cnt  <= 6'd1;
                        end else begin
                            bit_cnt <= cnt_inc;
                        end
                    end
                    ST_RDATA: if (sclk_fall) begin
                        if (bit_cnt < rd_len) begin
                            miso    <= tx_sr[0];
                            tx_sr   <= {1'b0, tx_sr[30:1]};
                            bit_cnt <= cnt_inc;
                        end else begin
                            miso <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef SPI_SLAVE_4BYTE_ADDR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            addr4 <= 1'b0;
        end else if (cmd_done) begin
            if (dec_set4)      addr4 <= 1'b1;
            else if (dec_clr4) addr4 <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_spi_slave_fl.sv
// Self-checking bench for spi_slave_fl: a mode-0 master drives directed and random transactions,
// a back-end responder answers read requests, and a reference model predicts requests and read data.
module tb_spi_slave_fl;

    localparam int TURN_CYC    = 1;
    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 8;
    localparam int REQ_W       = 73;
    localparam int CW          = 80;

    logic        clk = 1'b0;
    logic        rst, sclk, ss, mosi;
    logic        miso, miso_oe, req_valid, req_write;
    logic [7:0]  req_cmd;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = 32'h0;
    logic        busy, err_unknown, rsp_late;

    int checks = 0;
    int failures = 0;
    logic [REQ_W-1:0] exp_q[$];
    logic [REQ_W-1:0] got_q[$];
    int got_idx = 0;
    int err_cnt = 0;
    int late_cnt = 0;
    int oe_cnt = 0;
    bit rsp_en = 1'b1;
    int rsp_dly = 2;
    logic [31:0] rsp_word = 32'h0;
    int cd = 0;
    logic [63:0] rd;

    always #5 clk = ~clk;

    spi_slave_fl #(.TURN_CYC(TURN_CYC), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk         (clk),
        .rst         (rst),
        .sclk        (sclk),
        .ss          (ss),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_cmd     (req_cmd),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .busy        (busy),
        .err_unknown (err_unknown),
        .rsp_late    (rsp_late)
    );

    function automatic logic [REQ_W-1:0] mk_req(input logic wr, input logic [7:0] cmd,
                                                input logic [31:0] addr, input logic [31:0] wd);
        return {wr, cmd, addr, wd};
    endfunction

    function automatic int model_len(input logic [7:0] op);
        case (op)
            8'h03:   return 32;
            8'h05:   return 8;
            8'h9F:   return 24;
            default: return 0;
        endcase
    endfunction

    function automatic logic [63:0] model_read(input logic [7:0] op, input logic [31:0] word, input bit in_time);
        logic [63:0] mask;
        mask = (64'd1 << model_len(op)) - 64'd1;
        return in_time ? ({32'd0, word} & mask) : 64'd0;
    endfunction

    // Back end and event monitor: records requests, answers reads after rsp_dly clk.
    always @(negedge clk) begin
        rsp_valid = 1'b0;
        if (req_valid) begin
            got_q.push_back(mk_req(req_write, req_cmd,
                                   (req_cmd == 8'h03 || req_cmd == 8'h02) ? req_addr : 32'd0,
                                   req_write ? req_wdata : 32'd0));
            if (!req_write && rsp_en) cd = rsp_dly;
        end
        if (cd > 0) begin
            cd = cd - 1;
            if (cd == 0) begin
                rsp_valid = 1'b1;
                rsp_data  = rsp_word;
            end
        end
        if (err_unknown) err_cnt++;
        if (rsp_late) late_cnt++;
        if (miso_oe) oe_cnt++;
    end

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reqs(input string tag);
        check({tag, ":req_count"}, CW'(got_q.size() - got_idx), CW'(exp_q.size()));
        while (exp_q.size() > 0) begin
            if (got_idx < got_q.size())
                check({tag, ":req"}, CW'(got_q[got_idx]), CW'(exp_q[0]));
            void'(exp_q.pop_front());
            got_idx++;
        end
        got_idx = got_q.size();
    endtask

    task automatic spi_bit(input logic mo, output logic mi);
        mosi = mo;
        repeat (HALF) @(negedge clk);
        sclk = 1'b1;
        mi   = miso;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic txn(input logic [7:0] op, input logic [31:0] addr, input int alen,
                       input logic [31:0] wdata, input int wbits, input int rbits, input bit fast);
        logic mi;
        int   start;
        rd    = '0;
        start = 7;
        if (fast) begin
            ss   = 1'b0;
            mosi = op[7];
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk  = 1'b0;
            start = 6;
        end else begin
            ss = 1'b0;
        end
        for (int i = start; i >= 0; i--) spi_bit(op[i], mi);
        for (int i = alen - 1; i >= 0; i--) spi_bit(addr[i], mi);
        for (int i = 31; i >= 32 - wbits; i--) spi_bit(wdata[i], mi);
        if (rbits > 0)
            for (int i = 0; i < TURN_CYC; i++) spi_bit(1'b0, mi);
        for (int i = 0; i < rbits; i++) begin
            spi_bit(1'b0, mi);
            rd[i] = mi;
        end
        mosi = 1'b0;
    endtask

    task automatic release_ss();
        repeat (HALF) @(negedge clk);
        ss = 1'b1;
        repeat (SYNC_STAGES + 2) @(negedge clk);
    endtask

    task automatic end_checks(input string tag);
        check({tag, ":busy_end"}, CW'(busy), CW'(0));
        check({tag, ":oe_end"}, CW'(miso_oe), CW'(0));
        check({tag, ":miso_end"}, CW'(miso), CW'(0));
        check_reqs(tag);
        repeat (8) @(negedge clk);
    endtask

    task automatic run_read(input string tag, input logic [7:0] op, input logic [31:0] addr,
                            input int alen, input bit in_time);
        int e0, l0, o0;
        logic [31:0] eaddr;
        e0 = err_cnt;
        l0 = late_cnt;
        o0 = oe_cnt;
        eaddr = (alen == 32) ? addr : (addr & 32'h00FF_FFFF);
        exp_q.push_back(mk_req(1'b0, op, (op == 8'h03) ? eaddr : 32'd0, 32'd0));
        txn(op, addr, (op == 8'h03) ? alen : 0, 32'd0, 0, model_len(op) + 4, 1'b0);
        release_ss();
        check({tag, ":data"}, CW'(rd), CW'(model_read(op, rsp_word, in_time)));
        check({tag, ":late"}, CW'(late_cnt - l0), CW'(in_time ? 0 : 1));
        check({tag, ":err"}, CW'(err_cnt - e0), CW'(0));
        check({tag, ":oe_seen"}, CW'(oe_cnt > o0), CW'(1));
        end_checks(tag);
    endtask

    task automatic run_prog(input string tag, input logic [31:0] addr, input logic [31:0] data, input int wbits);
        if (wbits == 32) exp_q.push_back(mk_req(1'b1, 8'h02, addr & 32'h00FF_FFFF, data));
        txn(8'h02, addr, 24, data, wbits, 0, 1'b0);
        check({tag, ":busy_mid"}, CW'(busy), CW'(1));
        release_ss();
        end_checks(tag);
    endtask

    task automatic run_cmd(input string tag, input logic [7:0] op, input bit exp_req, input int exp_err, input bit fast);
        int e0, o0;
        e0 = err_cnt;
        o0 = oe_cnt;
        if (exp_req) exp_q.push_back(mk_req(1'b0, op, 32'd0, 32'd0));
        txn(op, 32'd0, 0, 32'd0, 0, 0, fast);
        release_ss();
        check({tag, ":err"}, CW'(err_cnt - e0), CW'(exp_err));
        check({tag, ":oe_quiet"}, CW'(oe_cnt - o0), CW'(0));
        end_checks(tag);
    endtask

    initial begin
        rst  = 1'b1;
        ss   = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        repeat (5) @(negedge clk);
        check("rst:miso", CW'(miso), CW'(0));
        check("rst:miso_oe", CW'(miso_oe), CW'(0));
        check("rst:req_valid", CW'(req_valid), CW'(0));
        check("rst:req_write", CW'(req_write), CW'(0));
        check("rst:req_cmd", CW'(req_cmd), CW'(0));
        check("rst:req_addr", CW'(req_addr), CW'(0));
        check("rst:req_wdata", CW'(req_wdata), CW'(0));
        check("rst:busy", CW'(busy), CW'(0));
        check("rst:err_unknown", CW'(err_unknown), CW'(0));
        check("rst:rsp_late", CW'(rsp_late), CW'(0));
        rst = 1'b0;
        repeat (6) @(negedge clk);

        rsp_en = 1'b1; rsp_dly = 3; rsp_word = 32'hA5A5_0F0F;
        run_read("read_basic", 8'h03, 32'h0001_2345, 24, 1'b1);

        run_prog("prog_basic", 32'h0000_0100, 32'hDEAD_BEEF, 32);
        run_prog("prog_abort", 32'h0000_0200, 32'h1234_5678, 20);

        rsp_en = 1'b0; rsp_word = 32'h0000_00C3;
        run_read("rdsr_withheld", 8'h05, 32'd0, 0, 1'b0);

        rsp_en = 1'b1; rsp_dly = 2; rsp_word = 32'h3C96_5AF1;
        run_read("read_after_late", 8'h03, 32'h00FE_DCBA, 24, 1'b1);

        rsp_dly = 40; rsp_word = 32'h0000_00FF;
        run_read("rdsr_too_late", 8'h05, 32'd0, 0, 1'b0);

        rsp_dly = 2;
        run_cmd("unknown_77", 8'h77, 1'b0, 1, 1'b0);
        run_cmd("wren_same_edge", 8'h06, 1'b1, 0, 1'b1);
        run_cmd("wrdi", 8'h04, 1'b1, 0, 1'b0);

        rsp_word = 32'h00C2_2017;
        run_read("rdid", 8'h9F, 32'd0, 0, 1'b1);

`ifdef SPI_SLAVE_4BYTE_ADDR_EN
        run_cmd("en4b", 8'hB7, 1'b0, 0, 1'b0);
        rsp_word = 32'h1357_9BDF;
        run_read("read_4byte", 8'h03, 32'h89AB_CDEF, 32, 1'b1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        rsp_word = 32'h2468_ACE0;
        run_read("read_3byte_after_rst", 8'h03, 32'h00AB_CDEF, 24, 1'b1);
`else
        run_cmd("b7_unknown", 8'hB7, 1'b0, 1, 1'b0);
        run_cmd("e9_unknown", 8'hE9, 1'b0, 1, 1'b0);
`endif

        // Reset in the middle of a READ address phase must drop it without a request.
        txn(8'h03, 32'h00AB_CDEF, 10, 32'd0, 0, 0, 1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        release_ss();
        end_checks("rst_mid_read");

        for (int it = 0; it < 10; it++) begin
            int kind;
            kind     = $urandom_range(0, 4);
            rsp_en   = 1'b1;
            rsp_dly  = $urandom_range(1, 6);
            rsp_word = $urandom();
            case (kind)
                0:       run_read("rnd_read", 8'h03, $urandom(), 24, 1'b1);
                1:       run_prog("rnd_prog", $urandom(), $urandom(), 32);
                2:       run_read("rnd_rdsr", 8'h05, 32'd0, 0, 1'b1);
                3:       run_read("rnd_rdid", 8'h9F, 32'd0, 0, 1'b1);
                default: run_cmd("rnd_wr", ($urandom_range(0, 1) != 0) ? 8'h06 : 8'h04, 1'b1, 0,
                                 bit'($urandom_range(0, 1)));
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
